// File: rtl/exu_oitf_ooo_pkg.sv
// Shared constants and the ITAG width derivation for the out-of-order OITF.
package exu_oitf_ooo_pkg;

    localparam int RFIDX_WIDTH        = 5;
    localparam int OITF_DEPTH_DEFAULT = 4;

    // A single-entry FIFO still needs a 1-bit tag so every port stays non-zero width.
    function automatic int oitf_itag_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/exu_oitf_ptr.sv
// Wrapping circular-buffer pointer with a lap flag; used for both alloc and retire.
module exu_oitf_ptr
    import exu_oitf_ooo_pkg::*;
#(
    parameter int  DEPTH  = OITF_DEPTH_DEFAULT,
    localparam int ITAG_W = oitf_itag_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inc,
    output logic [ITAG_W-1:0] ptr,
    output logic              flg
);

    localparam logic [ITAG_W-1:0] LAST = ITAG_W'(DEPTH - 1);

    logic [ITAG_W-1:0] ptr_q, ptr_d;
    logic              flg_q, flg_d;

    always_comb begin
        ptr_d = ptr_q;
        flg_d = flg_q;
        if (flush) begin
            ptr_d = '0;
            flg_d = 1'b0;
        end else if (inc) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
                flg_d = ~flg_q;
            end else begin
                ptr_d = ptr_q + ITAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            flg_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            flg_q <= flg_d;
        end
    end

    assign ptr = ptr_q;
    assign flg = flg_q;

endmodule

// File: rtl/exu_oitf_ooo.sv
// Outstanding-instruction track FIFO: in-order alloc/retire, out-of-order completion by ITAG.
// Optional macro OITF_FULL_BYPASS_EN lets a full FIFO accept a dispatch while its head retires.
module exu_oitf_ooo
    import exu_oitf_ooo_pkg::*;
#(
    parameter int  DEPTH   = OITF_DEPTH_DEFAULT,
    parameter int  NUM_CPL = 2,
    parameter int  RFIDX_W = RFIDX_WIDTH,
    localparam int ITAG_W  = oitf_itag_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic                      disp_rs1en,
    input  logic                      disp_rs2en,
    input  logic                      disp_rdwen,
    input  logic [RFIDX_W-1:0]        disp_rs1idx,
    input  logic [RFIDX_W-1:0]        disp_rs2idx,
    input  logic [RFIDX_W-1:0]        disp_rdidx,
    output logic [ITAG_W-1:0]         disp_itag,
    output logic                      match_rs1,
    output logic                      match_rs2,
    output logic                      match_rd,
    input  logic [NUM_CPL-1:0]        cpl_valid,
    input  logic [NUM_CPL*ITAG_W-1:0] cpl_itag,
    output logic                      ret_valid,
    input  logic                      ret_ready,
    output logic [ITAG_W-1:0]         ret_itag,
    output logic [RFIDX_W-1:0]        ret_rdidx,
    output logic                      ret_rdwen,
    output logic                      oitf_empty,
    output logic                      oitf_full,
    output logic [ITAG_W:0]           oitf_count
);

    localparam int CW = ITAG_W + 1;

    logic [DEPTH-1:0]   vld_q, vld_d, done_q, done_d, rdwen_q, rdwen_d;
    logic [RFIDX_W-1:0] rdidx_q [DEPTH];
    logic [RFIDX_W-1:0] rdidx_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [ITAG_W-1:0]  alloc_ptr, ret_ptr;
    logic               alloc_flg, ret_flg;
    logic               disp_fire, ret_fire;

    exu_oitf_ptr #(.DEPTH(DEPTH)) u_alloc_ptr (
        .clk(clk), .rst(rst), .flush(flush), .inc(disp_fire), .ptr(alloc_ptr), .flg(alloc_flg)
    );

    exu_oitf_ptr #(.DEPTH(DEPTH)) u_ret_ptr (
        .clk(clk), .rst(rst), .flush(flush), .inc(ret_fire), .ptr(ret_ptr), .flg(ret_flg)
    );

    if (DEPTH == 1) begin : g_one
        // Both pointers sit at 0, so occupancy is simply the single valid bit.
        logic unused_flg;
        assign unused_flg = alloc_flg ^ ret_flg;
        assign oitf_empty = ~vld_q[0];
        assign oitf_full  = vld_q[0];
    end else begin : g_multi
        assign oitf_empty = (alloc_ptr == ret_ptr) && (alloc_flg == ret_flg);
        assign oitf_full  = (alloc_ptr == ret_ptr) && (alloc_flg != ret_flg);
    end

    assign ret_valid = vld_q[ret_ptr] & done_q[ret_ptr] & ~flush;
    assign ret_fire  = ret_valid & ret_ready;
    assign ret_itag  = ret_ptr;
    assign ret_rdidx = rdidx_q[ret_ptr];
    assign ret_rdwen = rdwen_q[ret_ptr];

`ifdef OITF_FULL_BYPASS_EN
    assign disp_ready = (~oitf_full | ret_fire) & ~flush;
`else
    assign disp_ready = ~oitf_full & ~flush;
`endif
    assign disp_fire  = disp_valid & disp_ready;
    assign disp_itag  = alloc_ptr;
    assign oitf_count = count_q;

    always_comb begin
        match_rs1 = 1'b0;
        match_rs2 = 1'b0;
        match_rd  = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (vld_q[e] && rdwen_q[e]) begin
                match_rs1 = match_rs1 | (disp_rs1en & (rdidx_q[e] == disp_rs1idx));
                match_rs2 = match_rs2 | (disp_rs2en & (rdidx_q[e] == disp_rs2idx));
                match_rd  = match_rd  | (disp_rdwen & (rdidx_q[e] == disp_rdidx));
            end
        end
    end

    // Order matters: completion, then retire clears the head, then dispatch may reuse that slot.
    always_comb begin
        vld_d   = vld_q;
        done_d  = done_q;
        rdwen_d = rdwen_q;
        rdidx_d = rdidx_q;
        count_d = count_q + CW'(disp_fire) - CW'(ret_fire);
        for (int k = 0; k < NUM_CPL; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (cpl_valid[k] && (cpl_itag[k*ITAG_W +: ITAG_W] == ITAG_W'(e)))
                    done_d[e] = done_d[e] | vld_q[e];
            end
        end
        if (ret_fire) begin
            vld_d[ret_ptr]  = 1'b0;
            done_d[ret_ptr] = 1'b0;
        end
        if (disp_fire) begin
            vld_d[alloc_ptr]   = 1'b1;
            done_d[alloc_ptr]  = 1'b0;
            rdwen_d[alloc_ptr] = disp_rdwen;
            rdidx_d[alloc_ptr] = disp_rdidx;
        end
        if (flush) begin
            vld_d   = '0;
            done_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            done_q  <= '0;
            rdwen_q <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) rdidx_q[e] <= '0;
        end else begin
            vld_q   <= vld_d;
            done_q  <= done_d;
            rdwen_q <= rdwen_d;
            count_q <= count_d;
            rdidx_q <= rdidx_d;
        end
    end

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < NUM_CPL; gi++) begin : g_cpl_chk
        logic [ITAG_W-1:0] chk_tag;
        assign chk_tag = cpl_itag[gi*ITAG_W +: ITAG_W];
        a_cpl_live: assert property (@(posedge clk) disable iff (rst)
            (cpl_valid[gi] && !flush) |-> (vld_q[chk_tag] && !done_q[chk_tag]));
    end
`endif

endmodule

// File: tb/tb_exu_oitf_ooo.sv
// Directed table-driven bench for exu_oitf_ooo (DEPTH=4 instance) plus a DEPTH=3 wrap sequence.
`timescale 1ns/1ps
module tb_exu_oitf_ooo;

`ifdef OITF_FULL_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       flush, disp_valid, disp_rs1en, disp_rs2en, disp_rdwen, ret_ready;
    logic [4:0] disp_rs1idx, disp_rs2idx, disp_rdidx;
    logic [1:0] cpl_valid;
    logic [3:0] cpl_itag;
    logic       disp_ready, match_rs1, match_rs2, match_rd, ret_valid, ret_rdwen, oitf_empty, oitf_full;
    logic [1:0] disp_itag, ret_itag;
    logic [4:0] ret_rdidx;
    logic [2:0] oitf_count;

    // DEPTH=3 instance
    logic       d3_flush, d3_dv, d3_rs1en, d3_rs2en, d3_wen, d3_rr;
    logic [4:0] d3_rs1, d3_rs2, d3_rd;
    logic [1:0] d3_cv;
    logic [3:0] d3_ct;
    logic       d3_ready, d3_m1, d3_m2, d3_md, d3_rv, d3_rwen, d3_empty, d3_full;
    logic [1:0] d3_ditag, d3_ritag;
    logic [4:0] d3_rrd;
    logic [2:0] d3_count;

    exu_oitf_ooo #(.DEPTH(4), .NUM_CPL(2), .RFIDX_W(5)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
        .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
        .disp_itag(disp_itag), .match_rs1(match_rs1), .match_rs2(match_rs2), .match_rd(match_rd),
        .cpl_valid(cpl_valid), .cpl_itag(cpl_itag),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_itag(ret_itag),
        .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen),
        .oitf_empty(oitf_empty), .oitf_full(oitf_full), .oitf_count(oitf_count)
    );

    exu_oitf_ooo #(.DEPTH(3), .NUM_CPL(2), .RFIDX_W(5)) u_dut3 (
        .clk(clk), .rst(rst), .flush(d3_flush),
        .disp_valid(d3_dv), .disp_ready(d3_ready),
        .disp_rs1en(d3_rs1en), .disp_rs2en(d3_rs2en), .disp_rdwen(d3_wen),
        .disp_rs1idx(d3_rs1), .disp_rs2idx(d3_rs2), .disp_rdidx(d3_rd),
        .disp_itag(d3_ditag), .match_rs1(d3_m1), .match_rs2(d3_m2), .match_rd(d3_md),
        .cpl_valid(d3_cv), .cpl_itag(d3_ct),
        .ret_valid(d3_rv), .ret_ready(d3_rr), .ret_itag(d3_ritag),
        .ret_rdidx(d3_rrd), .ret_rdwen(d3_rwen),
        .oitf_empty(d3_empty), .oitf_full(d3_full), .oitf_count(d3_count)
    );

    typedef struct packed {
        logic       dv, wen;
        logic [4:0] rd;
        logic       r1en;
        logic [4:0] r1;
        logic       r2en;
        logic [4:0] r2;
        logic [1:0] cv, ct0, ct1;
        logic       rr, fl;
    } vin_t;

    typedef struct packed {
        logic       rdy;
        logic [1:0] ditag;
        logic       rv;
        logic [1:0] ritag;
        logic       m1, m2, md;
        logic [2:0] cnt;
        logic       emp, ful;
    } vexp_t;

    typedef struct packed {
        vin_t  i;
        vexp_t e;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [24];

    function automatic vec_t mk(input int dv, wen, rd, r1en, r1, r2en, r2, cv, ct0, ct1, rr, fl,
                                input int rdy, ditag, rv, ritag, m1, m2, md, cnt, emp, ful);
        vec_t t;
        t.i.dv = 1'(dv);   t.i.wen = 1'(wen);  t.i.rd = 5'(rd);
        t.i.r1en = 1'(r1en); t.i.r1 = 5'(r1); t.i.r2en = 1'(r2en); t.i.r2 = 5'(r2);
        t.i.cv = 2'(cv);   t.i.ct0 = 2'(ct0);  t.i.ct1 = 2'(ct1);
        t.i.rr = 1'(rr);   t.i.fl = 1'(fl);
        t.e.rdy = 1'(rdy); t.e.ditag = 2'(ditag); t.e.rv = 1'(rv); t.e.ritag = 2'(ritag);
        t.e.m1 = 1'(m1);   t.e.m2 = 1'(m2);    t.e.md = 1'(md);
        t.e.cnt = 3'(cnt); t.e.emp = 1'(emp);  t.e.ful = 1'(ful);
        return t;
    endfunction

    task automatic drive(input vin_t v);
        disp_valid  = v.dv;   disp_rdwen  = v.wen;  disp_rdidx = v.rd;
        disp_rs1en  = v.r1en; disp_rs1idx = v.r1;
        disp_rs2en  = v.r2en; disp_rs2idx = v.r2;
        cpl_valid   = v.cv;   cpl_itag    = {v.ct1, v.ct0};
        ret_ready   = v.rr;   flush       = v.fl;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    initial begin
        vexp_t act;
        vin_t  idle;

        //            dv wen rd r1en r1 r2en r2 cv ct0 ct1 rr fl | rdy ditag rv ritag m1 m2 md cnt emp ful
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 0, 7,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 1, 9,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[4]  = mk(1, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[5]  = mk(1, 1, 9,  1, 7, 1, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 4, 0, 1);
        tbl[6]  = mk(0, 1, 7,  1, 3, 0, 5, 2, 0, 2, 0, 0,   0, 0, 0, 0, 1, 0, 0, 4, 0, 1);
        tbl[7]  = mk(0, 0, 0,  0, 0, 0, 0, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 4, 0, 1);
        tbl[8]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, BYP, 0, 1, 0, 0, 0, 0, 4, 0, 1);
        tbl[9]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        tbl[10] = mk(0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        tbl[11] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 1, 0, 0, 0, 3, 0, 0);
        tbl[12] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 2, 0, 0, 0, 2, 0, 0);
        tbl[13] = mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 3, 0, 0, 0, 1, 0, 0);
        tbl[14] = mk(1, 1, 11, 0, 0, 0, 0, 1, 3, 0, 0, 0,   1, 1, 0, 3, 0, 0, 0, 2, 0, 0);
        tbl[15] = mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 1, 3, 0, 0, 0, 3, 0, 0);
        tbl[16] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, BYP, 3, 1, 3, 0, 0, 0, 4, 0, 1);
        tbl[17] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1-BYP, (BYP != 0) ? 0 : 3, 0, 0, 0, 0, 0, 3+BYP, 0, BYP);
        tbl[18] = mk(1, 1, 1,  0, 0, 0, 0, 3, 0, 1, 0, 1,   0, (BYP != 0) ? 0 : 3, 0, 0, 0, 0, 0, 3+BYP, 0, BYP);
        tbl[19] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(1, 1, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 0,  1, 4, 0, 0, 3, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[22] = mk(0, 0, 0,  1, 4, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        tbl[23] = mk(0, 0, 0,  1, 4, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0, 1, 0);

        idle = '0;
        drive(idle);
        d3_flush = 0; d3_dv = 0; d3_rs1en = 0; d3_rs2en = 0; d3_wen = 0; d3_rr = 0;
        d3_rs1 = 0; d3_rs2 = 0; d3_rd = 0; d3_cv = 0; d3_ct = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_empty", oitf_empty, 1);
        check("reset_full", oitf_full, 0);
        check("reset_count", oitf_count, 0);
        check("reset_ret_valid", ret_valid, 0);
        check("reset_disp_ready", disp_ready, 1);
        rst = 1'b0;

        for (int n = 0; n < 24; n++) begin
            drive(tbl[n].i);
            @(negedge clk);
            act.rdy = disp_ready; act.ditag = disp_itag; act.rv = ret_valid; act.ritag = ret_itag;
            act.m1 = match_rs1; act.m2 = match_rs2; act.md = match_rd;
            act.cnt = oitf_count; act.emp = oitf_empty; act.ful = oitf_full;
            n_cmp++;
            if (act !== tbl[n].e) begin
                n_err++;
                $display("FAIL vec%0d: got rdy=%b ditag=%0d rv=%b ritag=%0d m=%b%b%b cnt=%0d emp=%b ful=%b, expected rdy=%b ditag=%0d rv=%b ritag=%0d m=%b%b%b cnt=%0d emp=%b ful=%b",
                         n, act.rdy, act.ditag, act.rv, act.ritag, act.m1, act.m2, act.md, act.cnt, act.emp, act.ful,
                         tbl[n].e.rdy, tbl[n].e.ditag, tbl[n].e.rv, tbl[n].e.ritag, tbl[n].e.m1, tbl[n].e.m2,
                         tbl[n].e.md, tbl[n].e.cnt, tbl[n].e.emp, tbl[n].e.ful);
            end else begin
                $display("ok   vec%0d: rdy=%b ditag=%0d rv=%b ritag=%0d m=%b%b%b cnt=%0d emp=%b ful=%b",
                         n, act.rdy, act.ditag, act.rv, act.ritag, act.m1, act.m2, act.md, act.cnt, act.emp, act.ful);
            end
            @(posedge clk);
            #1;
        end

        // Head payload: dispatch rd=x12 into tag 1, complete it, then inspect the retire port.
        idle = '0;
        disp_valid = 1; disp_rdwen = 1; disp_rdidx = 5'd12;
        @(negedge clk);
        check("payload_disp_itag", disp_itag, 1);
        @(posedge clk); #1;
        drive(idle);
        cpl_valid = 2'b01; cpl_itag = 4'b0001;
        @(posedge clk); #1;
        cpl_valid = 2'b00;
        @(negedge clk);
        check("payload_ret_valid", ret_valid, 1);
        check("payload_ret_itag", ret_itag, 1);
        check("payload_ret_rdidx", ret_rdidx, 12);
        check("payload_ret_rdwen", ret_rdwen, 1);
        @(posedge clk); #1;

        // DEPTH=3: seven dispatch/complete/retire rounds wrap both pointers past 2.
        for (int i = 0; i < 7; i++) begin
            d3_dv = 1; d3_wen = 1; d3_rd = 5'(i);
            @(negedge clk);
            check($sformatf("d3_round%0d_disp_itag", i), d3_ditag, i % 3);
            check($sformatf("d3_round%0d_empty_before", i), d3_empty, 1);
            @(posedge clk); #1;
            d3_dv = 0; d3_cv = 2'b01; d3_ct = 4'(i % 3);
            @(negedge clk);
            check($sformatf("d3_round%0d_count", i), d3_count, 1);
            @(posedge clk); #1;
            d3_cv = 2'b00; d3_rr = 1;
            @(negedge clk);
            check($sformatf("d3_round%0d_ret_valid", i), d3_rv, 1);
            check($sformatf("d3_round%0d_ret_itag", i), d3_ritag, i % 3);
            @(posedge clk); #1;
            d3_rr = 0;
            @(negedge clk);
            check($sformatf("d3_round%0d_empty_after", i), d3_empty, 1);
            check($sformatf("d3_round%0d_full_after", i), d3_full, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            d3_dv = 1; d3_wen = 0; d3_rd = 5'd0;
            @(negedge clk);
            check($sformatf("d3_fill%0d_disp_itag", i), d3_ditag, (7 + i) % 3);
            @(posedge clk); #1;
        end
        d3_dv = 0;
        @(negedge clk);
        check("d3_fill_full", d3_full, 1);
        check("d3_fill_empty", d3_empty, 0);
        check("d3_fill_count", d3_count, 3);
        check("d3_fill_ready", d3_ready, 0);
        check("d3_fill_alloc_wrapped", d3_ditag, 1);
        @(posedge clk); #1;

        // Asynchronous reset in mid-operation: outputs return before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("arst_empty", oitf_empty, 1);
        check("arst_count", oitf_count, 0);
        check("arst_ret_valid", ret_valid, 0);
        check("arst_disp_itag", disp_itag, 0);
        check("arst_d3_full", d3_full, 0);
        check("arst_d3_count", d3_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_oitf_ooo.md
Name: exu_oitf_ooo

Overview:
Parametrised next-generation outstanding-instruction track FIFO for long-latency instructions (LSU, MUL/DIV).
- Allocates entries in program order at dispatch.
- Accepts out-of-order completion by ITAG on NUM_CPL completion channels.
- Retires entries in order from the head through a valid/ready handshake.
- Provides RAW/WAW hazard matches to dispatch and a single-cycle pipeline flush.
- Sits between disp and the long-pipe write-back arbiter.

Parameters:
- DEPTH, 4, number of entries; any value >= 1, power of two not required.
- NUM_CPL, 2, number of completion channels.
- RFIDX_W, 5, register index width.
- ITAG_W, max(1, clog2(DEPTH)), derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  entry available.
- disp_rs1en, disp_rs2en, disp_rdwen  in  1 each  operand/destination enables.
- disp_rs1idx, disp_rs2idx, disp_rdidx  in  RFIDX_W each  register indices.
- disp_itag  out  ITAG_W  tag assigned to the dispatching instruction (alloc pointer).
- match_rs1, match_rs2, match_rd  out  1 each  hazard against any valid entry with rdwen.
- cpl_valid  in  NUM_CPL  per-channel completion strobe.
- cpl_itag  in  NUM_CPL*ITAG_W  completing tags; channel k occupies bits [k*ITAG_W +: ITAG_W].
- ret_valid  out  1  head entry valid and done.
- ret_ready  in  1  write-back accepts.
- ret_itag  out  ITAG_W  head tag.
- ret_rdidx  out  RFIDX_W  head rdidx.
- ret_rdwen  out  1  head rdwen.
- oitf_empty  out  1  no valid entries.
- oitf_full  out  1  all entries valid.
- oitf_count  out  ITAG_W+1  number of valid entries.

Behaviour:
- Per-entry state: vld, done, rdwen, rdidx.
- Pointers:
  - alloc and retire pointers each carry a wrap flag.
  - A pointer at DEPTH-1 advances to 0 and toggles its flag.
  - empty = pointers equal and flags equal; full = pointers equal and flags differ.
  - DEPTH=1: pointers are constant 0; empty = ~vld[0]; full = vld[0].
- Reset values: pointers 0, flags 0, all vld/done 0; outputs oitf_empty=1, oitf_full=0, oitf_count=0, disp_ready=1, ret_valid=0, disp_itag=0, ret_itag=0, all match_*=0.
- Dispatch:
  - disp_fire = disp_valid & disp_ready & ~flush.
  - On fire: entry[alloc] gets vld=1, done=0, rdwen, rdidx; alloc pointer advances.
- Completion:
  - For each k with cpl_valid[k], done[cpl_itag[k]] is set next cycle, provided that entry is vld.
  - Multiple channels may hit the same or different tags in one cycle; the effect is a bitwise OR.
  - Completion to an invalid or already-done entry is ignored and fires a simulation-only assertion.
- Retire:
  - ret_valid = vld[head] & done[head], combinational from registers.
  - ret_fire = ret_valid & ret_ready & ~flush; it clears vld and done at the head and advances the retire pointer.
  - A completion arriving in the same cycle as the head's retire does not set ret_valid until the next cycle (latency completion->ret_valid = 1 cycle).
- Simultaneous dispatch and retire are both applied; count is unchanged.
- Matches:
  - match_rs1 = OR over entries of vld & rdwen & disp_rs1en & (rdidx==disp_rs1idx); rs2 and rd are analogous.
  - Matches are purely combinational, include done-but-unretired entries, and are independent of disp_valid.
- Flush:
  - Highest priority over dispatch, completion and retire.
  - Next cycle: all vld/done 0, pointers and flags 0, count 0.
  - disp_ready and ret_valid are forced 0 during the flush cycle.
- Reset asserted mid-operation returns all state to reset values asynchronously.
- oitf_count is registered and updated as +disp_fire -ret_fire; it is 0 on flush.

Optional Feature:
OITF_FULL_BYPASS_EN
- Defined: disp_ready = (~oitf_full | ret_fire) & ~flush. A full FIFO accepts a dispatch in the cycle its head retires; this creates a combinational path ret_ready->disp_ready.
- Undefined: disp_ready = ~oitf_full & ~flush, with no path from ret_ready.

Decomposition:
- The shared defines hold RFIDX_WIDTH and the default OITF depth.
- The ITAG_W derivation lives in one shared function.
- One sub-module, exu_oitf_ptr (ITAG_W-wide wrap pointer with flag, parameter DEPTH, inputs clk/rst/flush/inc, outputs ptr/flg), is instantiated for both alloc and retire.

Test Plan:
1. DEPTH=4: dispatch 4 instructions, no completions -> disp_itag 0,1,2,3; oitf_full=1; disp_ready=0; oitf_count=4.
2. Complete tag 2 then tag 0 on channel 1 -> ret_valid rises only after tag 0 completes; ret_itag=0 retires, then tag 1 waits; ret_valid=0 until tag 1 completes.
3. Full FIFO, head done, ret_ready=1 with a dispatch pending -> with OITF_FULL_BYPASS_EN the dispatch fires the same cycle and count stays 4; without it, disp_ready=0.
4. Entry holding rd=x5 with rdwen=1 and dispatch rs2idx=5 with rs2en=1 -> match_rs2=1, match_rs1=0; with rdwen=0 in the entry -> all match_*=0.
5. DEPTH=3: 7 dispatch/retire pairs -> the pointer wraps 2->0, the flag toggles, and empty/full stay correct.
6. Flush with 3 entries and a simultaneous dispatch and completion -> next cycle oitf_empty=1, count=0, disp_itag=0, no allocation.
